// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the FSM state encoding, the fetch-packet field layout, the default
// reset PC and small PC arithmetic helpers used by fetch_stage.
package if_pkg;

    // Fetch FSM states; two bits so the encoding matches legacy constants.
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        PUSH  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    // Fetch packet layout: {instr, PC, PC+4}
    localparam int INSTR_HI = 95;
    localparam int INSTR_LO = 64;
    localparam int PC_HI    = 63;
    localparam int PC_LO    = 32;
    localparam int PCP4_HI  = 31;
    localparam int PCP4_LO  = 0;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    // Sequential successor; wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Redirect targets are word aligned; the two low bits are forced to zero.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage and its environment.
// Groups the instruction-memory handshake, the branch redirect input and the
// IF->ID FIFO push interface.
//   master : the fetch stage (drives imem request, push and counter)
//   slave  : memory / FIFO / branch unit side
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        pushing;
    logic [95:0] out_data;
    logic        push_must_wait;
    logic [31:0] fetched_count;

    modport master (
        output imem_req, imem_addr, pushing, out_data, fetched_count,
        input  imem_valid, imem_data, redirect_valid, redirect_pc, push_must_wait
    );

    modport slave (
        input  imem_req, imem_addr, pushing, out_data, fetched_count,
        output imem_valid, imem_data, redirect_valid, redirect_pc, push_must_wait
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage.
// Issues one-cycle read requests to instruction memory from the PC, builds a
// 96-bit packet {instr, PC, PC+4} from each response and pushes it into the
// IF->ID FIFO, waiting while push_must_wait is high. Redirects reload the PC
// and discard whatever fetch is still in flight.
// Ports:
//   CLK   : clock, all state changes on posedge
//   RESET : synchronous active-low reset
//   bus   : fetch_stage_if master (imem handshake, redirect, FIFO push,
//           fetched_count)
module fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
    parameter int          ELEM_SIZE_BITS = 96
) (
    input  logic           CLK,
    input  logic           RESET,
    fetch_stage_if.master  bus
);

    localparam logic [1:0] ST_REQ   = REQ;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_PUSH  = PUSH;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    logic [1:0]                state_r, state_s;
    logic [31:0]               pc_r, pc_s;
    logic                      req_r, req_s;
    logic [31:0]               addr_r, addr_s;
    logic                      push_r, push_s;
    logic [ELEM_SIZE_BITS-1:0] data_r, data_s;
    logic [31:0]               count_r, count_s;
    logic                      accept_s;

    // Next-state, next-PC and next-output computation for the fetch FSM.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        req_s    = 1'b0;
        addr_s   = addr_r;
        push_s   = push_r;
        data_s   = data_r;
        accept_s = (state_r == ST_PUSH) && !bus.push_must_wait;

        // An accepted push counts even when a redirect drops it; the
        // downstream stage flushes that packet itself.
        if (accept_s) begin
            count_s = count_r + 32'd1;
        end else begin
            count_s = count_r;
        end

        case (state_r)
            ST_REQ: begin
                // The request goes out on this edge with the current PC; if a
                // redirect lands now, that request is stale and its response
                // has to be drained before fetching from the new target.
                req_s  = 1'b1;
                addr_s = pc_r;
                if (bus.redirect_valid) begin
                    pc_s    = align_pc(bus.redirect_pc);
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.redirect_valid) begin
                    pc_s = align_pc(bus.redirect_pc);
                    if (bus.imem_valid) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end else if (bus.imem_valid) begin
                    data_s[INSTR_HI:INSTR_LO] = bus.imem_data;
                    data_s[PC_HI:PC_LO]       = pc_r;
                    data_s[PCP4_HI:PCP4_LO]   = pc_plus4(pc_r);
                    push_s                    = 1'b1;
                    state_s                   = ST_PUSH;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_PUSH: begin
                if (bus.redirect_valid) begin
                    pc_s    = align_pc(bus.redirect_pc);
                    push_s  = 1'b0;
                    state_s = ST_REQ;
                end else if (accept_s) begin
                    pc_s    = pc_plus4(pc_r);
                    push_s  = 1'b0;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_PUSH;
                end
            end
            ST_DRAIN: begin
                if (bus.redirect_valid) begin
                    pc_s = align_pc(bus.redirect_pc);
                end else begin
                    pc_s = pc_r;
                end
                // Leave once the stale response has been swallowed, even if a
                // further redirect arrives with it: nothing else is in flight.
                if (bus.imem_valid) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_REQ;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r <= ST_REQ;
            pc_r    <= RESET_PC;
            req_r   <= 1'b0;
            addr_r  <= RESET_PC;
            push_r  <= 1'b0;
            data_r  <= '0;
            count_r <= 32'd0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            req_r   <= req_s;
            addr_r  <= addr_s;
            push_r  <= push_s;
            data_r  <= data_s;
            count_r <= count_s;
        end
    end

    assign bus.imem_req      = req_r;
    assign bus.imem_addr     = addr_r;
    assign bus.pushing       = push_r;
    assign bus.out_data      = data_r;
    assign bus.fetched_count = count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected request
// addresses and packets into queues; monitors pop and compare whenever the DUT
// issues a request or has a push accepted. A behavioural memory answers each
// request after a programmable latency with data = addr ^ MEM_KEY.
module tb_fetch_stage;

    localparam logic [31:0] MEM_KEY = 32'h2048_0005;

    logic CLK = 1'b0;
    logic RESET;

    fetch_stage_if bus_if ();

    fetch_stage dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_if)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_req[$];
    logic [95:0] exp_pkt[$];

    int          mem_lat = 1;
    int          mem_pend = 0;
    logic [31:0] mem_addr = 32'd0;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_imem_req",  96'(bus_if.imem_req), 96'd0);
        check("rst_imem_addr", 96'(bus_if.imem_addr), 96'h0040_0000);
        check("rst_pushing",   96'(bus_if.pushing), 96'd0);
        check("rst_out_data",  bus_if.out_data, 96'd0);
        check("rst_count",     96'(bus_if.fetched_count), 96'd0);
    endtask

    task automatic wait_count(input logic [31:0] target, input int limit);
        int n = 0;
        while (bus_if.fetched_count !== target && n < limit) begin
            @(negedge CLK);
            n++;
        end
        check("wait_fetched_count", 96'(bus_if.fetched_count), 96'(target));
    endtask

    task automatic wait_push(input int limit);
        int n = 0;
        while (bus_if.pushing !== 1'b1 && n < limit) begin
            @(negedge CLK);
            n++;
        end
        check("wait_pushing", 96'(bus_if.pushing), 96'd1);
    endtask

    task automatic wait_req(input int limit);
        int n = 0;
        while (bus_if.imem_req !== 1'b1 && n < limit) begin
            @(negedge CLK);
            n++;
        end
        check("wait_imem_req", 96'(bus_if.imem_req), 96'd1);
    endtask

    // Behavioural instruction memory with fixed latency, cleared by reset.
    initial begin
        bus_if.imem_valid = 1'b0;
        bus_if.imem_data  = 32'd0;
        forever begin
            @(negedge CLK);
            #1;
            bus_if.imem_valid = 1'b0;
            if (!RESET) begin
                mem_pend = 0;
            end else begin
                if (mem_pend > 0) begin
                    mem_pend--;
                    if (mem_pend == 0) begin
                        bus_if.imem_valid = 1'b1;
                        bus_if.imem_data  = mem_addr ^ MEM_KEY;
                    end
                end
                if (bus_if.imem_req) begin
                    mem_pend = mem_lat;
                    mem_addr = bus_if.imem_addr;
                end
            end
        end
    end

    // Scoreboard monitor: compares every request and every accepted push.
    initial begin
        forever begin
            @(negedge CLK);
            #1;
            if (bus_if.imem_req === 1'b1) begin
                if (exp_req.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: got addr %h expected no request", bus_if.imem_addr);
                end else begin
                    check("imem_addr", 96'(bus_if.imem_addr), 96'(exp_req.pop_front()));
                end
            end
            if (bus_if.pushing === 1'b1 && bus_if.push_must_wait === 1'b0) begin
                if (exp_pkt.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_push: got %h expected no push", bus_if.out_data);
                end else begin
                    check("out_data", bus_if.out_data, exp_pkt.pop_front());
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        RESET                 = 1'b0;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = 32'd0;
        bus_if.push_must_wait = 1'b0;
        repeat (2) @(negedge CLK);
        check_reset_outputs();

        // Basic fetch, latency 1, no back-pressure.
        exp_req.push_back(32'h0040_0000);
        exp_req.push_back(32'h0040_0004);
        exp_pkt.push_back(96'h20080005_00400000_00400004);
        RESET = 1'b1;
        wait_count(32'd1, 30);

        // Back-pressure on the second packet for five cycles.
        bus_if.push_must_wait = 1'b1;
        exp_pkt.push_back(96'h20080001_00400004_00400008);
        exp_req.push_back(32'h0040_0008);
        wait_push(30);
        for (int i = 0; i < 5; i++) begin
            check("stall_out_data", bus_if.out_data, 96'h20080001_00400004_00400008);
            check("stall_no_req",   96'(bus_if.imem_req), 96'd0);
            check("stall_count",    96'(bus_if.fetched_count), 96'd1);
            @(negedge CLK);
        end
        bus_if.push_must_wait = 1'b0;
        mem_lat = 3;
        @(negedge CLK);
        check("release_req_gap", 96'(bus_if.imem_req), 96'd0);
        @(negedge CLK);
        check("release_req", 96'(bus_if.imem_req), 96'd1);

        // Redirect during WAIT: stale response drained, fetch resumes at target.
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h0040_0103;
        exp_req.push_back(32'h0040_0100);
        @(negedge CLK);
        bus_if.redirect_valid = 1'b0;
        check("count_after_wait_redirect", 96'(bus_if.fetched_count), 96'd2);
        exp_pkt.push_back(96'h20080105_00400100_00400104);
        wait_push(40);

        // Redirect coinciding with an accepted push; target exercises wrap.
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'hFFFF_FFFF;
        exp_req.push_back(32'hFFFF_FFFC);
        exp_pkt.push_back(96'hDFB7FFF9_FFFFFFFC_00000000);
        @(negedge CLK);
        bus_if.redirect_valid = 1'b0;
        check("count_push_redirect",   96'(bus_if.fetched_count), 96'd3);
        check("pushing_push_redirect", 96'(bus_if.pushing), 96'd0);
        exp_req.push_back(32'h0000_0000);
        wait_count(32'd4, 40);

        // Reset pulse while waiting on memory.
        wait_req(20);
        RESET = 1'b0;
        @(negedge CLK);
        check_reset_outputs();
        exp_req.push_back(32'h0040_0000);
        exp_pkt.push_back(96'h20080005_00400000_00400004);
        RESET = 1'b1;
        wait_count(32'd1, 40);

        // Hold the next packet in the FIFO stall and let queues settle.
        bus_if.push_must_wait = 1'b1;
        exp_req.push_back(32'h0040_0004);
        repeat (10) @(negedge CLK);
        check("final_pushing",   96'(bus_if.pushing), 96'd1);
        check("final_out_data",  bus_if.out_data, 96'h20080001_00400004_00400008);
        check("req_queue_empty", 96'(exp_req.size()), 96'd0);
        check("pkt_queue_empty", 96'(exp_pkt.size()), 96'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
